// File: rtl/flow_control_credit_nport.sv
// -----------------------------------------------------------------------------
// flow_control_credit_nport
//
// Per-output switch allocator and credit tracker for an N-port mesh router.
// It sits between the input FIFOs / route compute and the crossbar.
//
// For every output j:
//   * In IDLE, it arbitrates round-robin among the inputs whose head flit
//     routes to j. It starts the scan at rr_ptr[j] and wraps upward.
//   * Once a head flit without the tail marker is sent, the grant is locked to
//     that input until its tail flit is sent (wormhole switching).
//   * A credit counter tracks the free slots in the downstream buffer. A flit
//     is sent only while credit is non-zero.
//
// Transfers are zero-latency. The pop enable, crossbar select and valid are
// all combinational from the current inputs and state.
//
// Ports
//   clk         clock
//   rst_n       synchronous active-low reset; also gates the outputs to 0
//   req         [i*NPORT+j] head flit of input i routes to output j
//   empty       input FIFO i is empty
//   tail        head flit of input FIFO i is a tail flit
//   credit_in   1-cycle pulse: downstream of output j freed one slot
//   en_fifo     pop input FIFO i this cycle
//   out_sw      [j*NPORT+i] output j is driven by input i (one-hot or zero)
//   out_valid   a flit is transferred on output j this cycle
//   credit_cnt  [j*CW +: CW] current credits for output j
//   credit_err  sticky: credit_in arrived while the counter was full
// -----------------------------------------------------------------------------
module flow_control_credit_nport #(
  parameter  int NPORT        = 3,
  parameter  int CREDIT_DEPTH = 4,
  localparam int CW           = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORT*NPORT-1:0] req,
  input  logic [NPORT-1:0]       empty,
  input  logic [NPORT-1:0]       tail,
  input  logic [NPORT-1:0]       credit_in,
  output logic [NPORT-1:0]       en_fifo,
  output logic [NPORT*NPORT-1:0] out_sw,
  output logic [NPORT-1:0]       out_valid,
  output logic [NPORT*CW-1:0]    credit_cnt,
  output logic                   credit_err
);

  localparam int              PW         = $clog2(NPORT);
  localparam logic [CW-1:0]   CREDIT_MAX = CW'(CREDIT_DEPTH);
  localparam logic [PW-1:0]   LAST_PORT  = PW'(NPORT - 1);

  // One FSM per output. BUSY means the output is locked to r_lock_own.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          r_state    [NPORT];
  logic [PW-1:0]   r_lock_own [NPORT];
  logic [PW-1:0]   r_rr_ptr   [NPORT];
  logic [CW-1:0]   r_credit   [NPORT];
  logic            r_credit_err;

  state_e          w_state_nxt    [NPORT];
  logic [PW-1:0]   w_lock_own_nxt [NPORT];
  logic [PW-1:0]   w_rr_ptr_nxt   [NPORT];
  logic [CW-1:0]   w_credit_nxt   [NPORT];
  logic            w_credit_err_nxt;

  // ---------------------------------------------------------------------------
  // Selection signals
  // ---------------------------------------------------------------------------
  logic [NPORT-1:0] w_owned;              // input i owns some locked output
  logic [NPORT-1:0] w_cand   [NPORT];     // IDLE candidates per output
  logic [PW:0]      w_pick   [NPORT];     // {found, index} from round-robin
  logic [NPORT-1:0] w_has_credit;
  logic [NPORT-1:0] w_sel_vld;            // output j has a selected input
  logic [PW-1:0]    w_sel    [NPORT];     // selected input for output j
  logic [NPORT-1:0] w_xfer;               // a flit moves on output j

  // Round-robin pick: the first set bit of cand at or above ptr, with
  // wrap-around. The scan runs from the farthest offset down to offset 0, so
  // the nearest candidate is assigned last and wins. This form needs no
  // early exit.
  function automatic logic [PW:0] rr_pick(input logic [NPORT-1:0] cand,
                                          input logic [PW-1:0]    ptr);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int off = NPORT - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NPORT) idx -= NPORT;
      if (cand[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  // An input that already owns a locked output may not win another output.
  // Together with the one-request-per-input rule, this keeps each input
  // granted by at most one output.
  always_comb begin : owned_p
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    w_owned = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (r_state[j] == S_BUSY) w_owned[r_lock_own[j]] = 1'b1;
    end
  end

  always_comb begin : select_p
    w_has_credit = '0;
    w_sel_vld    = '0;
    w_xfer       = '0;
    for (int j = 0; j < NPORT; j++) begin
      w_cand[j] = '0;
      for (int i = 0; i < NPORT; i++) begin
        w_cand[j][i] = req[i*NPORT + j] & ~empty[i] & ~w_owned[i];
      end
      w_pick[j]       = rr_pick(w_cand[j], r_rr_ptr[j]);
      w_has_credit[j] = (r_credit[j] != '0);

      if (r_state[j] == S_BUSY) begin
        // The owner stays selected even while stalled on empty or credit, so
        // the crossbar path remains set up for the rest of the packet.
        w_sel_vld[j] = 1'b1;
        w_sel[j]     = r_lock_own[j];
      end else begin
        // No credit means no winner, so the crossbar row stays at zero.
        w_sel_vld[j] = w_pick[j][PW] & w_has_credit[j];
        w_sel[j]     = w_pick[j][PW-1:0];
      end

      w_xfer[j] = w_sel_vld[j] & ~empty[w_sel[j]] & w_has_credit[j];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (forced to zero while reset is asserted)
  // ---------------------------------------------------------------------------
  always_comb begin : out_p
    en_fifo   = '0;
    out_sw    = '0;
    out_valid = '0;
    if (rst_n) begin
      for (int j = 0; j < NPORT; j++) begin
        if (w_sel_vld[j]) out_sw[j*NPORT + int'(w_sel[j])] = 1'b1;
        out_valid[j] = w_xfer[j];
        if (w_xfer[j]) en_fifo[w_sel[j]] = 1'b1;
      end
    end
  end

  always_comb begin : credit_pack_p
    credit_cnt = '0;
    for (int j = 0; j < NPORT; j++) begin
      credit_cnt[j*CW +: CW] = r_credit[j];
    end
  end

  assign credit_err = r_credit_err;

  // ---------------------------------------------------------------------------
  // Next state: lock FSM, round-robin pointer, credits
  // ---------------------------------------------------------------------------
  always_comb begin : next_p
    w_credit_err_nxt = r_credit_err;
    for (int j = 0; j < NPORT; j++) begin
      w_state_nxt[j]    = r_state[j];
      w_lock_own_nxt[j] = r_lock_own[j];
      w_rr_ptr_nxt[j]   = r_rr_ptr[j];
      w_credit_nxt[j]   = r_credit[j];

      if (w_xfer[j]) begin
        case (r_state[j])
          S_IDLE: begin
            // Only a head transfer moves the pointer. It moves just past the
            // winner, so that input has the lowest priority next time.
            w_rr_ptr_nxt[j] = (w_sel[j] == LAST_PORT) ? '0 : w_sel[j] + 1'b1;
            if (!tail[w_sel[j]]) begin
              w_state_nxt[j]    = S_BUSY;
              w_lock_own_nxt[j] = w_sel[j];
            end
          end
          S_BUSY: begin
            if (tail[w_sel[j]]) w_state_nxt[j] = S_IDLE;
          end
          default: w_state_nxt[j] = S_IDLE;
        endcase
      end

      // A transfer and a returning credit in the same cycle cancel out.
      case ({w_xfer[j], credit_in[j]})
        2'b10: w_credit_nxt[j] = r_credit[j] - 1'b1;
        2'b01: begin
          if (r_credit[j] == CREDIT_MAX) w_credit_err_nxt = 1'b1;
          else                           w_credit_nxt[j]  = r_credit[j] + 1'b1;
        end
        default: w_credit_nxt[j] = r_credit[j];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: all per-output state arrays are reset. They are small control
      // registers, not a RAM, and a reset in mid-packet must drop the lock.
      for (int j = 0; j < NPORT; j++) begin
        r_state[j]    <= S_IDLE;
        r_lock_own[j] <= '0;
        r_rr_ptr[j]   <= '0;
        r_credit[j]   <= CREDIT_MAX;
      end
      r_credit_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here. Every register samples the
      // pre-edge values, whatever order the statements are in.
      for (int j = 0; j < NPORT; j++) begin
        r_state[j]    <= w_state_nxt[j];
        r_lock_own[j] <= w_lock_own_nxt[j];
        r_rr_ptr[j]   <= w_rr_ptr_nxt[j];
        r_credit[j]   <= w_credit_nxt[j];
      end
      r_credit_err <= w_credit_err_nxt;
    end
  end

endmodule

// File: tb/tb_flow_control_credit_nport.sv
// -----------------------------------------------------------------------------
// tb_flow_control_credit_nport
//
// Bench for flow_control_credit_nport with NPORT=3 and CREDIT_DEPTH=4.
//
// Each input FIFO is modelled as a queue of flits (dest*2 + tail). The queue
// drives req/empty/tail and is popped whenever en_fifo pops it. Each test
// pushes the transfers it expects into a scoreboard as {output, source,
// cycle}. Every observed out_valid pops one entry and compares it. en_fifo is
// compared every cycle against the sources popped in that cycle.
//
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_flow_control_credit_nport;

  localparam int NP = 3;
  localparam int CD = 4;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*NP-1:0]  req;
  logic [NP-1:0]     empty;
  logic [NP-1:0]     tail;
  logic [NP-1:0]     credit_in;
  logic [NP-1:0]     en_fifo;
  logic [NP*NP-1:0]  out_sw;
  logic [NP-1:0]     out_valid;
  logic [NP*CW-1:0]  credit_cnt;
  logic              credit_err;

  always #5 clk = ~clk;

  flow_control_credit_nport #(
    .NPORT        (NP),
    .CREDIT_DEPTH (CD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .empty      (empty),
    .tail       (tail),
    .credit_in  (credit_in),
    .en_fifo    (en_fifo),
    .out_sw     (out_sw),
    .out_valid  (out_valid),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  typedef struct {
    int out_p;
    int src;
    int cyc;
  } exp_t;

  exp_t sb [$];
  int   fifo_q [NP][$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic load(input int i, input int dest, input bit t);
    fifo_q[i].push_back(dest * 2 + int'(t));
  endtask

  task automatic expect_xfer(input int o, input int s, input int c);
    exp_t e;
    e.out_p = o;
    e.src   = s;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic drive_inputs();
    int f;
    req = '0;
    for (int i = 0; i < NP; i++) begin
      if (fifo_q[i].size() > 0) begin
        f        = fifo_q[i][0];
        empty[i] = 1'b0;
        tail[i]  = f[0];
        req[i*NP + (f >> 1)] = 1'b1;
      end else begin
        empty[i] = 1'b1;
        tail[i]  = 1'b0;
      end
    end
  endtask

  // Scoreboard comparator: pops one expected transfer per observed out_valid.
  task automatic score();
    logic [NP-1:0] exp_en;
    int            src;
    exp_t          e;
    exp_en = '0;
    for (int j = 0; j < NP; j++) begin
      if (out_valid[j] === 1'b1) begin
        src = -1;
        for (int i = 0; i < NP; i++) begin
          if (out_sw[j*NP + i] === 1'b1) src = (src == -1) ? i : -2;
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("FAIL xfer_unexpected: cyc %0d out %0d src %0d, want no transfer",
                   cyc, j, src);
        end else begin
          e = sb.pop_front();
          if (e.out_p != j || e.src != src || e.cyc != cyc) begin
            n_mis++;
            $display("FAIL xfer: got out %0d src %0d cyc %0d, want out %0d src %0d cyc %0d",
                     j, src, cyc, e.out_p, e.src, e.cyc);
          end
          exp_en[e.src] = 1'b1;
        end
      end
    end
    n_cmp++;
    if (en_fifo !== exp_en) begin
      n_mis++;
      $display("FAIL en_fifo: cyc %0d got %b, want %b", cyc, en_fifo, exp_en);
    end
    for (int i = 0; i < NP; i++) begin
      if (en_fifo[i] === 1'b1 && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    end
  endtask

  task automatic cycle_begin(input logic [NP-1:0] cin);
    credit_in = cin;
    drive_inputs();
    @(negedge clk);
    score();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    credit_in = '0;
    cyc++;
  endtask

  task automatic step(input logic [NP-1:0] cin);
    cycle_begin(cin);
    cycle_end();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    credit_in = '0;
    for (int i = 0; i < NP; i++) fifo_q[i].delete();
    sb.delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    credit_in = '0;
    req       = '0;
    req[0]    = 1'b1;          // input 0 -> output 0, FIFO non-empty
    empty     = 3'b110;
    tail      = 3'b111;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== '0) begin
      n_mis++; $display("FAIL reset_out_valid: got %b, want 000", out_valid);
    end
    n_cmp++;
    if (en_fifo !== '0) begin
      n_mis++; $display("FAIL reset_en_fifo: got %b, want 000", en_fifo);
    end
    n_cmp++;
    if (out_sw !== '0) begin
      n_mis++; $display("FAIL reset_out_sw: got %b, want 0", out_sw);
    end
    @(posedge clk);
    #1;
    req   = '0;
    empty = '1;
    tail  = '0;
    rst_n = 1'b1;
    cyc   = 0;
    n_cmp++;
    if (credit_cnt !== {3'd4, 3'd4, 3'd4}) begin
      n_mis++; $display("FAIL reset_credit_cnt: got %h, want %h", credit_cnt, {3'd4, 3'd4, 3'd4});
    end
    n_cmp++;
    if (credit_err !== 1'b0) begin
      n_mis++; $display("FAIL reset_credit_err: got %b, want 0", credit_err);
    end
    step('0);
    n_cmp++;
    if (out_sw !== '0) begin
      n_mis++; $display("FAIL idle_out_sw: got %b, want 0", out_sw);
    end
  endtask

  task automatic test_single_flit();
    do_reset();
    load(0, 2, 1'b1);
    expect_xfer(2, 0, 0);
    cycle_begin('0);
    n_cmp++;
    if (out_valid !== 3'b100) begin
      n_mis++; $display("FAIL single_out_valid: got %b, want 100", out_valid);
    end
    n_cmp++;
    if (out_sw[8:6] !== 3'b001) begin
      n_mis++; $display("FAIL single_out_sw_row2: got %b, want 001", out_sw[8:6]);
    end
    cycle_end();
    n_cmp++;
    if (credit_cnt[8:6] !== 3'd3) begin
      n_mis++; $display("FAIL single_credit2: got %0d, want 3", credit_cnt[8:6]);
    end
    // With rr_ptr[2]=1, input 1 now wins over input 0.
    load(0, 2, 1'b1);
    load(1, 2, 1'b1);
    expect_xfer(2, 1, 1);
    expect_xfer(2, 0, 2);
    step('0);
    step('0);
    n_cmp++;
    if (credit_cnt[8:6] !== 3'd1) begin
      n_mis++; $display("FAIL single_credit2_after: got %0d, want 1", credit_cnt[8:6]);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL single_drained: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_wormhole();
    do_reset();
    load(1, 0, 1'b0);
    load(1, 0, 1'b0);
    load(1, 0, 1'b1);
    load(2, 0, 1'b1);
    expect_xfer(0, 1, 0);
    expect_xfer(0, 1, 1);
    expect_xfer(0, 1, 2);
    expect_xfer(0, 2, 3);
    for (int k = 0; k < 3; k++) begin
      cycle_begin('0);
      n_cmp++;
      if (out_sw[2:0] !== 3'b010 || en_fifo[2] !== 1'b0) begin
        n_mis++; $display("FAIL wormhole_lock: cyc %0d got sw %b en2 %b, want sw 010 en2 0",
                          cyc, out_sw[2:0], en_fifo[2]);
      end
      cycle_end();
    end
    step('0);
    n_cmp++;
    if (credit_cnt[2:0] !== 3'd0) begin
      n_mis++; $display("FAIL wormhole_credit0: got %0d, want 0", credit_cnt[2:0]);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL wormhole_drained: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) load(i, 1, 1'b1);
    end
    for (int k = 0; k < 6; k++) expect_xfer(1, k % NP, k);
    repeat (6) step(3'b010);
    n_cmp++;
    if (credit_cnt[5:3] !== 3'd4 || credit_err !== 1'b0) begin
      n_mis++; $display("FAIL rr_credit: got cnt %0d err %b, want cnt 4 err 0",
                        credit_cnt[5:3], credit_err);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL rr_drained: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_credit_exhaustion();
    do_reset();
    for (int k = 0; k < 4; k++) load(0, 0, 1'b0);
    load(0, 0, 1'b1);
    for (int k = 0; k < 4; k++) expect_xfer(0, 0, k);
    expect_xfer(0, 0, 6);
    repeat (4) step('0);
    n_cmp++;
    if (credit_cnt[2:0] !== 3'd0) begin
      n_mis++; $display("FAIL exh_credit0: got %0d, want 0", credit_cnt[2:0]);
    end
    cycle_begin('0);
    n_cmp++;
    if (out_valid[0] !== 1'b0 || out_sw[2:0] !== 3'b001) begin
      n_mis++; $display("FAIL exh_blocked: got valid %b sw %b, want valid 0 sw 001",
                        out_valid[0], out_sw[2:0]);
    end
    cycle_end();
    cycle_begin(3'b001);
    n_cmp++;
    if (out_valid[0] !== 1'b0) begin
      n_mis++; $display("FAIL exh_pulse_cycle: got valid %b, want 0", out_valid[0]);
    end
    cycle_end();
    n_cmp++;
    if (credit_cnt[2:0] !== 3'd1) begin
      n_mis++; $display("FAIL exh_credit1: got %0d, want 1", credit_cnt[2:0]);
    end
    step('0);
    // Output 0 is now IDLE with zero credit, so there is no winner and the row
    // stays at zero.
    load(1, 0, 1'b1);
    cycle_begin('0);
    n_cmp++;
    if (out_sw[2:0] !== 3'b000 || out_valid[0] !== 1'b0) begin
      n_mis++; $display("FAIL exh_idle_nocredit: got sw %b valid %b, want sw 000 valid 0",
                        out_sw[2:0], out_valid[0]);
    end
    cycle_end();
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL exh_drained: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 3; k++) load(0, 0, 1'b1);
    for (int k = 0; k < 3; k++) expect_xfer(0, 0, k);
    step('0);
    step('0);
    step(3'b001);
    n_cmp++;
    if (credit_cnt[2:0] !== 3'd2) begin
      n_mis++; $display("FAIL simul_credit2: got %0d, want 2", credit_cnt[2:0]);
    end
    step(3'b001);
    step(3'b001);
    n_cmp++;
    if (credit_cnt[2:0] !== 3'd4 || credit_err !== 1'b0) begin
      n_mis++; $display("FAIL simul_full: got cnt %0d err %b, want cnt 4 err 0",
                        credit_cnt[2:0], credit_err);
    end
    step(3'b001);
    n_cmp++;
    if (credit_cnt[2:0] !== 3'd4 || credit_err !== 1'b1) begin
      n_mis++; $display("FAIL simul_overflow: got cnt %0d err %b, want cnt 4 err 1",
                        credit_cnt[2:0], credit_err);
    end
    repeat (3) step('0);
    n_cmp++;
    if (credit_err !== 1'b1) begin
      n_mis++; $display("FAIL simul_err_sticky: got %b, want 1", credit_err);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL simul_drained: got %0d pending, want 0", sb.size());
    end
    do_reset();
    n_cmp++;
    if (credit_err !== 1'b0) begin
      n_mis++; $display("FAIL simul_err_cleared: got %b, want 0", credit_err);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    load(0, 1, 1'b1);
    load(1, 2, 1'b1);
    load(2, 0, 1'b1);
    expect_xfer(0, 2, 0);
    expect_xfer(1, 0, 0);
    expect_xfer(2, 1, 0);
    step('0);
    n_cmp++;
    if (credit_cnt !== {3'd3, 3'd3, 3'd3}) begin
      n_mis++; $display("FAIL parallel_credit: got %h, want %h", credit_cnt, {3'd3, 3'd3, 3'd3});
    end
    // While input 0 owns output 0, its next flit asks for output 1. It must
    // not also be granted there.
    do_reset();
    load(0, 0, 1'b0);
    load(0, 1, 1'b1);
    expect_xfer(0, 0, 0);
    expect_xfer(0, 0, 1);
    repeat (3) step('0);
    n_cmp++;
    if (credit_cnt[5:3] !== 3'd4) begin
      n_mis++; $display("FAIL owned_excluded_credit1: got %0d, want 4", credit_cnt[5:3]);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++; $display("FAIL parallel_drained: got %0d pending, want 0", sb.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_flit();
    test_wormhole();
    test_round_robin();
    test_credit_exhaustion();
    test_simultaneous();
    test_parallel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flow_control_credit_nport.md
Name: flow_control_credit_nport

Overview:
- Parametrised successor to the 3-port router flow control, for N ports.
- Per output port, it arbitrates among input FIFOs with round-robin priority and locks the grant for a whole packet (wormhole).
- It tracks downstream buffer space with per-output credit counters, and drives the FIFO pop enables and crossbar selects.
- It sits between the input FIFOs / route compute and the crossbar of each router in the mesh.

Parameters:
- NPORT, 3, number of router ports (inputs = outputs); legal 2..8.
- CREDIT_DEPTH, 4, downstream buffer depth per output; legal 1..15.
- CW, $clog2(CREDIT_DEPTH+1), credit counter width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NPORT*NPORT  request matrix; bit [i*NPORT+j] = head flit of input i routes to output j; at most one bit set per input.
- empty  in  NPORT  input FIFO i empty.
- tail  in  NPORT  flit at head of FIFO i is a tail flit; single-flit packets have tail=1.
- credit_in  in  NPORT  1-cycle pulse: downstream of output j freed one slot.
- en_fifo  out  NPORT  pop input FIFO i this cycle.
- out_sw  out  NPORT*NPORT  crossbar select; bit [j*NPORT+i] = output j driven by input i; one-hot or zero per output.
- out_valid  out  NPORT  flit transferred on output j this cycle.
- credit_cnt  out  NPORT*CW  current credits per output.
- credit_err  out  1  sticky: credit_in received with counter already at CREDIT_DEPTH.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - credit_cnt[j]=CREDIT_DEPTH; all locks cleared; rr_ptr[j]=0; credit_err=0.
  - While rst_n=0, en_fifo, out_sw and out_valid are forced to 0 combinationally.
  - Reset mid-packet drops the lock; there is no recovery of partial packets.
- State per output j:
  - lock_vld[j] (1b), lock_own[j] (log2 NPORT), rr_ptr[j] (log2 NPORT), credit_cnt[j] (CW).
- Output FSM per j:
  - IDLE (lock_vld=0): candidates are inputs i with req[i][j]=1, empty[i]=0, and i not owner of any other locked output.
  - In IDLE, the winner is the first candidate at or after rr_ptr[j], scanning upward with wrap-around. There is no winner if credit_cnt[j]==0.
  - BUSY (lock_vld=1): the owner is lock_own[j]; req is ignored for that input.
- Transfer on output j in a cycle, zero latency:
  - Condition: a selected input s exists (winner or owner), empty[s]=0, and credit_cnt[j]!=0.
  - Then out_valid[j]=1 and en_fifo[s]=1.
  - out_sw row j is one-hot s whenever s exists, even if blocked on empty/credit in BUSY; otherwise 0.
- Transitions:
  - IDLE->BUSY at the clock edge after a transfer with tail[s]=0: lock_own=s.
  - IDLE transfer with tail[s]=1 stays IDLE.
  - BUSY->IDLE at the clock edge after a transfer with tail[s]=1.
  - rr_ptr[j] = (s+1) mod NPORT, updated only on a head transfer from IDLE.
- Credits:
  - Transfer with no credit_in: decrement.
  - credit_in with no transfer: increment.
  - Both in the same cycle: unchanged.
  - credit_in with no transfer at CREDIT_DEPTH: hold the value and set credit_err.
  - Counter never underflows; zero credit blocks the transfer.
- Each input is granted by at most one output per cycle; en_fifo[i] = OR of its transfers.
- Requests with multiple bits set per input are illegal; behaviour is then undefined and not checked.

Test Plan:
- Reset: hold rst_n=0 2 cycles, NPORT=3, CREDIT_DEPTH=4 -> credit_cnt all 4, en_fifo=0, out_sw=0, credit_err=0.
- Single-flit: input 0 req output 2, tail=1, empty=0 -> same cycle out_valid[2]=1, en_fifo[0]=1, out_sw row2=001; next cycle credit_cnt[2]=3, rr_ptr[2]=1.
- Wormhole lock: input 1 sends a 3-flit packet to output 0 while input 2 also requests output 0 -> 3 consecutive transfers from input 1, input 2 stalled (en_fifo[2]=0); input 2 is granted the cycle after input 1's tail.
- Round-robin: inputs 0, 1, 2 all stream single-flit packets to output 1 with ample credit -> grant order 0,1,2,0,1,2.
- Credit exhaustion: 4 transfers to output 0 with no credit_in -> credit_cnt[0]=0, 5th flit blocked (out_valid[0]=0, out_sw still selects owner if locked); one credit_in pulse -> transfer next cycle.
- Simultaneous: transfer and credit_in on same cycle at cnt=2 -> stays 2; credit_in at cnt=4 -> cnt stays 4, credit_err=1 and remains 1 until reset.
